ram_rd_arbiter: RTL and testbench

- Shares the single pixel-memory read port (read_addressp / re_p / qp) of the on-chip RAM among NUM_REQ engines (convolution, pooling, dense) using round-robin arbitration.
- Registers the winning address toward the RAM and returns the read data, tagged to the granted requester, two cycles after grant.
- Sits between the layer engines and the RAM block.
- Supports locked bursts, so an engine can stream consecutive pixels without interleaving from other engines.

---
 rtl/ram_rd_arbiter_if.sv | 24 ++
 rtl/ram_rd_arbiter.sv | 98 +++++++++
 tb/tb_ram_rd_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ram_rd_arbiter_if.sv
// Requester-side bus of the pixel read arbiter: per-engine request/lock/address
// in, one-hot grant and tagged read data out.
interface ram_rd_arbiter_if #(
  parameter int NUM_REQ          = 3,
  parameter int SIZE_1           = 12,
  parameter int SIZE_address_pix = 13
);
  logic [NUM_REQ-1:0]                  req;
  logic [NUM_REQ-1:0]                  lock;
  logic [NUM_REQ*SIZE_address_pix-1:0] addr;
  logic [NUM_REQ-1:0]                  gnt;
  logic [NUM_REQ-1:0]                  rvalid;
  logic [SIZE_1-1:0]                   rdata;

  modport master (
    output req, lock, addr,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, addr,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_rd_arbiter.sv
// Round-robin arbiter sharing the RAM pixel read port among NUM_REQ engines,
// with locked bursts and a two-stage tagged return pipeline.
module ram_rd_arbiter #(
  parameter int NUM_REQ          = 3,
  parameter int SIZE_1           = 12,
  parameter int SIZE_address_pix = 13
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ram_rd_arbiter_if.slave             bus,
  output logic [SIZE_address_pix-1:0] read_addressp,
  output logic                        re_p,
  input  logic [SIZE_1-1:0]           qp,
  output logic                        busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  logic [PW-1:0]               r_ptr;
  logic [PW-1:0]               r_owner;
  logic                        r_own_v;
  logic                        r_v1;
  logic [PW-1:0]               r_tag1;
  logic [SIZE_address_pix-1:0] r_addr;
  logic                        r_v2;
  logic [PW-1:0]               r_tag2;

  logic                        w_any;
  logic [PW-1:0]               w_idx;
  logic [NUM_REQ-1:0]          w_gnt;

  // A live lock owner with its request up wins outright; otherwise scan from ptr.
  always_comb begin : arb
    int            c;
    logic [PW-1:0] w_c;
    c     = 0;
    w_c   = '0;
    w_any = 1'b0;
    w_idx = '0;
    w_gnt = '0;
    if (r_own_v && bus.req[r_owner]) begin
      w_any = 1'b1;
      w_idx = r_owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        c = int'(r_ptr) + k;
        if (c >= NUM_REQ) c = c - NUM_REQ;
        w_c = PW'(c);
        if (!w_any && bus.req[w_c]) begin
          w_any = 1'b1;
          w_idx = w_c;
        end
      end
    end
    if (w_any && rst_n) w_gnt[w_idx] = 1'b1;
  end

  assign bus.gnt = w_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_own_v <= 1'b0;
      r_v1    <= 1'b0;
      r_tag1  <= '0;
      r_addr  <= '0;
      r_v2    <= 1'b0;
      r_tag2  <= '0;
    end else begin
      r_v1   <= w_any;
      r_tag1 <= w_idx;
      r_v2   <= r_v1;
      r_tag2 <= r_tag1;
      if (w_any) begin
        r_addr  <= bus.addr[w_idx*SIZE_address_pix +: SIZE_address_pix];
        r_ptr   <= (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
        r_owner <= w_idx;
        r_own_v <= bus.lock[w_idx];
      end else begin
        // No grant means nobody is requesting, so any lock owner has let go.
        r_own_v <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rvalid = '0;
    if (r_v2) bus.rvalid[r_tag2] = 1'b1;
  end

  assign bus.rdata     = rst_n ? qp : '0;
  assign read_addressp = r_addr;
  assign re_p          = r_v1;
  assign busy          = r_v1 | r_v2;

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Directed bench for ram_rd_arbiter: behavioural RAM with registered read,
// hand-written grant sequences, and a 2-deep expected-return tracker.
module tb_ram_rd_arbiter;
  localparam int NR = 3;
  localparam int DW = 12;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] read_addressp;
  logic          re_p;
  logic [DW-1:0] qp = '0;
  logic          busy;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;

  // Expected stage-1 / stage-2 contents (valid, one-hot requester, address)
  logic          p1v = 1'b0, p2v = 1'b0;
  logic [NR-1:0] p1g = '0, p2g = '0;
  logic [AW-1:0] p1a = '0, p2a = '0;

  ram_rd_arbiter_if #(.NUM_REQ(NR), .SIZE_1(DW), .SIZE_address_pix(AW)) bus ();

  ram_rd_arbiter #(.NUM_REQ(NR), .SIZE_1(DW), .SIZE_address_pix(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .read_addressp (read_addressp),
    .re_p          (re_p),
    .qp            (qp),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (re_p) qp <= mem[read_addressp];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, then check every output against expectations.
  task automatic step(input string tag, input logic [NR-1:0] r, input logic [NR-1:0] l,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [NR-1:0] eg);
    @(posedge clk);
    #1;
    bus.req  = r;
    bus.lock = l;
    bus.addr = {a2, a1, a0};
    @(negedge clk);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
    chk({tag, ".re_p"}, 32'(re_p), 32'(p1v));
    if (p1v) chk({tag, ".raddr"}, 32'(read_addressp), 32'(p1a));
    chk({tag, ".rvalid"}, 32'(bus.rvalid), p2v ? 32'(p2g) : 32'd0);
    if (p2v) chk({tag, ".rdata"}, 32'(bus.rdata), 32'(mem[p2a]));
    chk({tag, ".busy"}, 32'(busy), 32'(p1v | p2v));
    $display("cycle %s req=%b lock=%b gnt=%b re_p=%b raddr=%0d rvalid=%b rdata=%h busy=%b",
             tag, r, l, bus.gnt, re_p, read_addressp, bus.rvalid, bus.rdata, busy);
    p2v = p1v; p2g = p1g; p2a = p1a;
    p1v = (eg != '0);
    p1g = eg;
    p1a = eg[0] ? a0 : (eg[1] ? a1 : a2);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.lock = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p1v = 1'b0; p2v = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'((i * 37 + 11) & 12'hFFF);
    mem[5] = 12'h123;
    bus.req  = '0;
    bus.lock = '0;
    bus.addr = '0;

    // Reset state
    #2;
    chk("rst.gnt", 32'(bus.gnt), 0);
    chk("rst.re_p", 32'(re_p), 0);
    chk("rst.raddr", 32'(read_addressp), 0);
    chk("rst.rvalid", 32'(bus.rvalid), 0);
    chk("rst.rdata", 32'(bus.rdata), 0);
    chk("rst.busy", 32'(busy), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Single request: mem[5]=0x123 comes back two cycles after grant
    step("single0", 3'b001, 3'b000, 13'd5, 13'd0, 13'd0, 3'b001);
    step("single1", 3'b000, 3'b000, 13'd0, 13'd0, 13'd0, 3'b000);
    chk("single.raddr5", 32'(read_addressp), 32'd5);
    step("single2", 3'b000, 3'b000, 13'd0, 13'd0, 13'd0, 3'b000);
    chk("single.data123", 32'(bus.rdata), 32'h123);
    step("single3", 3'b000, 3'b000, 13'd0, 13'd0, 13'd0, 3'b000);

    // Round robin over all three
    do_reset();
    step("rr0", 3'b111, 3'b000, 13'd20, 13'd21, 13'd22, 3'b001);
    step("rr1", 3'b111, 3'b000, 13'd20, 13'd21, 13'd22, 3'b010);
    step("rr2", 3'b111, 3'b000, 13'd20, 13'd21, 13'd22, 3'b100);
    step("rr3", 3'b111, 3'b000, 13'd20, 13'd21, 13'd22, 3'b001);
    step("rr4", 3'b111, 3'b000, 13'd20, 13'd21, 13'd22, 3'b010);
    step("rr5", 3'b111, 3'b000, 13'd20, 13'd21, 13'd22, 3'b100);
    step("rr6", 3'b000, 3'b000, 13'd0, 13'd0, 13'd0, 3'b000);
    step("rr7", 3'b000, 3'b000, 13'd0, 13'd0, 13'd0, 3'b000);

    // Locked burst by requester 1 starves requester 0 until lock drops
    do_reset();
    step("lk0", 3'b011, 3'b010, 13'd30, 13'd40, 13'd0, 3'b001);
    step("lk1", 3'b011, 3'b010, 13'd30, 13'd41, 13'd0, 3'b010);
    step("lk2", 3'b011, 3'b010, 13'd30, 13'd42, 13'd0, 3'b010);
    step("lk3", 3'b011, 3'b000, 13'd30, 13'd43, 13'd0, 3'b010);
    step("lk4", 3'b011, 3'b000, 13'd31, 13'd44, 13'd0, 3'b001);
    step("lk5", 3'b000, 3'b000, 13'd0, 13'd0, 13'd0, 3'b000);
    step("lk6", 3'b000, 3'b000, 13'd0, 13'd0, 13'd0, 3'b000);

    // Back-to-back stream from requester 2, addrs 10..17
    for (int i = 0; i < 8; i++)
      step($sformatf("st%0d", i), 3'b100, 3'b000, 13'd0, 13'd0, 13'(10 + i), 3'b100);
    step("st8", 3'b000, 3'b000, 13'd0, 13'd0, 13'd0, 3'b000);
    step("st9", 3'b000, 3'b000, 13'd0, 13'd0, 13'd0, 3'b000);
    step("st10", 3'b000, 3'b000, 13'd0, 13'd0, 13'd0, 3'b000);

    // Reset while a read is in flight: it must never return
    step("mf0", 3'b010, 3'b000, 13'd0, 13'd50, 13'd0, 3'b010);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req = '0;
    @(negedge clk);
    chk("mf.rst.gnt", 32'(bus.gnt), 0);
    chk("mf.rst.re_p", 32'(re_p), 0);
    chk("mf.rst.raddr", 32'(read_addressp), 0);
    chk("mf.rst.rvalid", 32'(bus.rvalid), 0);
    chk("mf.rst.rdata", 32'(bus.rdata), 0);
    chk("mf.rst.busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    p1v = 1'b0; p2v = 1'b0;
    @(negedge clk);
    chk("mf.after.rvalid", 32'(bus.rvalid), 0);
    chk("mf.after.busy", 32'(busy), 0);
    step("mf2", 3'b111, 3'b000, 13'd60, 13'd61, 13'd62, 3'b001);
    step("mf3", 3'b000, 3'b000, 13'd0, 13'd0, 13'd0, 3'b000);
    step("mf4", 3'b000, 3'b000, 13'd0, 13'd0, 13'd0, 3'b000);

    // Idle
    for (int i = 0; i < 10; i++)
      step($sformatf("idle%0d", i), 3'b000, 3'b000, 13'd0, 13'd0, 13'd0, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
